// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: slot occupancy encoding and the RISC-V NOP word
// for stages that prefer a NOP bubble over all-zero.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by reset.
// Single-cycle update, no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_stage_reg.sv
// Inter-stage pipeline register with valid/ready, synchronous flush, optional 2-entry skid
// buffer (registered IN_READY) and a saturating stall counter; 1-cycle latency.
module pipe_skid_stage_reg
  import pipe_pkg::*;
#(
  parameter int                PC_W    = 32,
  parameter int                DATA_W  = 32,
  parameter bit                SKID_EN = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE  = '0,
  parameter int                CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [PC_W-1:0]   IN_PC,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [PC_W-1:0]   OUT_PC,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CNT_W-1:0]  STALL_CNT
);

  localparam int               ENT_W      = PC_W + DATA_W;
  localparam logic [ENT_W-1:0] BUBBLE_ENT = {{PC_W{1'b0}}, BUBBLE};

  typedef enum logic [1:0] {SEL_HOLD, SEL_IN, SEL_SKID, SEL_BUBBLE} main_sel_t;

  state_t           state_q, state_d;
  main_sel_t        main_sel;
  logic             skid_load;
  logic [ENT_W-1:0] main_q, skid_q;
  logic             in_fire;

  assign in_fire   = IN_VALID & IN_READY;
  assign OUT_VALID = (state_q != ST_EMPTY);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (FLUSH) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_BUSY;
        ST_BUSY: begin
          if (in_fire && !OUT_READY && SKID_EN) state_d = ST_FULL;
          else if (!in_fire && OUT_READY)       state_d = ST_EMPTY;
        end
        ST_FULL:  if (OUT_READY) state_d = ST_BUSY;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Leaving a slot empty reloads the bubble, so the outputs stay pure flop outputs.
  always_comb begin
    main_sel  = SEL_HOLD;
    skid_load = 1'b0;
    if (FLUSH) begin
      main_sel = SEL_BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) main_sel = SEL_IN;
        ST_BUSY: begin
          if (in_fire && OUT_READY) main_sel  = SEL_IN;
          else if (in_fire)         skid_load = 1'b1;
          else if (OUT_READY)       main_sel  = SEL_BUBBLE;
        end
        ST_FULL:  if (OUT_READY) main_sel = SEL_SKID;
        default:  main_sel = SEL_BUBBLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      main_q <= BUBBLE_ENT;
      skid_q <= BUBBLE_ENT;
    end else begin
      case (main_sel)
        SEL_IN:     main_q <= {IN_PC, IN_DATA};
        SEL_SKID:   main_q <= skid_q;
        SEL_BUBBLE: main_q <= BUBBLE_ENT;
        SEL_HOLD:   main_q <= main_q;
      endcase
      if (skid_load) skid_q <= {IN_PC, IN_DATA};
    end
  end

  assign {OUT_PC, OUT_DATA} = main_q;

  generate
    if (SKID_EN) begin : g_skid
      logic in_ready_q;
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != ST_FULL);
        end
      end
      assign IN_READY = in_ready_q;
    end else begin : g_noskid
      assign IN_READY = OUT_READY | ~OUT_VALID;
    end
  endgenerate

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (OUT_VALID & ~OUT_READY),
    .count (STALL_CNT)
  );

endmodule
